// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_arbiter_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // MIPS funct codes understood by the shared ALU
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   function automatic logic [NUM_REQ-1:0] owner_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU: MIPS funct decode, no overflow trap.
// Unrecognised codes fall back to an unsigned add.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MODE_WIDTH = 6
) (
   input  logic [DATA_WIDTH-1:0] i_a,
   input  logic [DATA_WIDTH-1:0] i_b,
   input  logic [MODE_WIDTH-1:0] i_mode,
   output logic [DATA_WIDTH-1:0] o_y
);

   always_comb begin
      o_y = i_a + i_b;
      case (i_mode)
         MODE_WIDTH'(FN_ADD): o_y = i_a + i_b;
         MODE_WIDTH'(FN_SUB): o_y = i_a - i_b;
         MODE_WIDTH'(FN_AND): o_y = i_a & i_b;
         MODE_WIDTH'(FN_OR):  o_y = i_a | i_b;
         MODE_WIDTH'(FN_SLT): o_y = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         default:             o_y = i_a + i_b;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_rr_arb2.sv
// Combinational 2-way grant; round-robin on last winner, or fixed priority to
// requester 0 when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
   import alu_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] i_valid,
   input  logic               i_last,
   output logic [NUM_REQ-1:0] o_grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = i_last;

   always_comb begin
      o_grant    = '0;
      o_grant[0] = i_valid[0];
      o_grant[1] = i_valid[1] & ~i_valid[0];
   end
`else
   // The requester that did not win last time has priority on a tie
   always_comb begin
      o_grant = '0;
      if (i_last) begin
         o_grant[0] = i_valid[0];
         o_grant[1] = i_valid[1] & ~i_valid[0];
      end else begin
         o_grant[1] = i_valid[1];
         o_grant[0] = i_valid[0] & ~i_valid[1];
      end
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two valid/ready requesters: accept, execute, respond (>=3 cycles/op).
// Result is held until the owner's rsp_ready; ALU_ARB_FIXED_PRIO_EN selects fixed priority.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int MODE_WIDTH = 6
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req_valid,
   output logic [NUM_REQ-1:0]        o_req_ready,
   input  logic [2*DATA_WIDTH-1:0]   i_req_a,
   input  logic [2*DATA_WIDTH-1:0]   i_req_b,
   input  logic [2*MODE_WIDTH-1:0]   i_req_mode,
   output logic [NUM_REQ-1:0]        o_rsp_valid,
   input  logic [NUM_REQ-1:0]        i_rsp_ready,
   output logic [DATA_WIDTH-1:0]     o_rsp_result,
   output logic                      o_rsp_zero,
   output logic                      o_busy
);

   state_e                  state_q, state_d;
   logic                    last_q, last_d;
   logic                    owner_q, owner_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   logic [MODE_WIDTH-1:0]   mode_q, mode_d;
   logic [DATA_WIDTH-1:0]   result_q, result_d;
   logic                    zero_q, zero_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic                    busy_q, busy_d;
   logic [NUM_REQ-1:0]      grant;
   logic [DATA_WIDTH-1:0]   alu_y;

   rr_arb2 u_arb (
      .i_valid (i_req_valid),
      .i_last  (last_q),
      .o_grant (grant)
   );

   // ALU only ever sees the registered operands
   alu_arbiter_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .MODE_WIDTH (MODE_WIDTH)
   ) u_alu (
      .i_a    (a_q),
      .i_b    (b_q),
      .i_mode (mode_q),
      .o_y    (alu_y)
   );

   assign o_req_ready = (state_q == ST_IDLE) ? grant : '0;

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      owner_d     = owner_q;
      a_d         = a_q;
      b_d         = b_q;
      mode_d      = mode_q;
      result_d    = result_q;
      zero_d      = zero_q;
      rsp_valid_d = rsp_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (o_req_ready != '0) begin
               owner_d = o_req_ready[1];
               a_d     = o_req_ready[1] ? i_req_a[2*DATA_WIDTH-1:DATA_WIDTH]    : i_req_a[DATA_WIDTH-1:0];
               b_d     = o_req_ready[1] ? i_req_b[2*DATA_WIDTH-1:DATA_WIDTH]    : i_req_b[DATA_WIDTH-1:0];
               mode_d  = o_req_ready[1] ? i_req_mode[2*MODE_WIDTH-1:MODE_WIDTH] : i_req_mode[MODE_WIDTH-1:0];
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            result_d    = alu_y;
            zero_d      = (alu_y == '0);
            rsp_valid_d = owner_onehot(owner_q);
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (i_rsp_ready[owner_q]) begin
               rsp_valid_d = '0;
               last_d      = owner_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         mode_q      <= '0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         rsp_valid_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         owner_q     <= owner_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mode_q      <= mode_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_result = result_q;
   assign o_rsp_zero   = zero_q;
   assign o_busy       = busy_q;

endmodule
